// File: rtl/crc8_frame_assembler.sv
// Feeds an external pipelined CRC engine with {msg, K'b0}, parks each message in a FIFO
// until its CRC returns LAT cycles later, and emits {msg, crc} on a valid/ready output.
module crc8_frame_assembler #(
    parameter int N     = 64,
    parameter int K     = 8,
    parameter int LAT   = 63,
    parameter int DEPTH = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   msg_in,
    output logic [N+K-1:0] crc_msg,
    input  logic [K-1:0]   crc_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+K-1:0] out_frame
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [N-1:0]  msg_mem [DEPTH];
    logic [K-1:0]  crc_mem [DEPTH];

    logic [PW-1:0] msg_wr_ptr, crc_wr_ptr, rd_ptr;
    logic [PW-1:0] msg_wr_ptr_nxt, crc_wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0] occ_nxt;
    logic [AW-1:0] head_idx_nxt;
    logic [K-1:0]  head_crc_nxt;

    logic           vld_p0;
    logic [LAT-1:0] vld_pipe;
    logic           accept;
    logic           pop;
    logic           crc_push;

    assign accept    = in_valid && in_ready;
    assign out_valid = (crc_wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign crc_push  = vld_pipe[LAT-1];

    always_comb begin
        msg_wr_ptr_nxt = msg_wr_ptr + PW'(accept);
        crc_wr_ptr_nxt = crc_wr_ptr + PW'(crc_push);
        rd_ptr_nxt     = rd_ptr + PW'(pop);
        occ_nxt        = msg_wr_ptr_nxt - rd_ptr_nxt;
        head_idx_nxt   = rd_ptr_nxt[AW-1:0];
        head_crc_nxt   = crc_mem[head_idx_nxt];
        // An empty crc FIFO receiving a push makes the incoming CRC the new head.
        if (crc_push && (crc_wr_ptr[AW-1:0] == head_idx_nxt))
            head_crc_nxt = crc_in;
    end

    // Stage p0: engine input register and its valid; vld_pipe tracks the engine latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_msg  <= '0;
            vld_p0   <= 1'b0;
            vld_pipe <= '0;
        end else begin
            crc_msg     <= accept ? {msg_in, {K{1'b0}}} : '0;
            vld_p0      <= accept;
            vld_pipe[0] <= vld_p0;
            for (int i = 1; i < LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Buffer and output stage: pointers, credit-based in_ready, registered frame head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_wr_ptr <= '0;
            crc_wr_ptr <= '0;
            rd_ptr     <= '0;
            in_ready   <= 1'b0;
            out_frame  <= '0;
        end else begin
            msg_wr_ptr <= msg_wr_ptr_nxt;
            crc_wr_ptr <= crc_wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            in_ready   <= (occ_nxt < PW'(DEPTH));
            if (crc_wr_ptr_nxt != rd_ptr_nxt)
                out_frame <= {msg_mem[head_idx_nxt], head_crc_nxt};
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            msg_mem[msg_wr_ptr[AW-1:0]] <= msg_in;
        if (crc_push)
            crc_mem[crc_wr_ptr[AW-1:0]] <= crc_in;
    end

endmodule
